// File: rtl/panel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : panel_pkg
// Brief    : Shared defaults for the front-panel input block.
// Revision : 1.0
// ============================================================================
package panel_pkg;

    localparam int CLOCK_HZ    = 12_000_000;
    localparam int DEBOUNCE_MS = 20;

    localparam int DEBOUNCE_CYCLES_DEF = (CLOCK_HZ / 1000) * DEBOUNCE_MS;
    // The +1 keeps 2^CNT_W strictly above the cycle count even for exact powers of two.
    localparam int CNT_W_DEF           = $clog2(DEBOUNCE_CYCLES_DEF + 1);
    localparam bit ACTIVE_LOW_DEF      = 1'b1;

endpackage : panel_pkg
`default_nettype wire

// File: rtl/panel_inputs_debounce_channel.sv
`default_nettype none
// ============================================================================
// Module   : debounce_channel
// Brief    : One channel: 2-flop synchroniser, debounce counter, sticky flags.
// Revision : 1.0
// ============================================================================
module debounce_channel
    import panel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw,
    input  logic clear,
    output logic state,
    output logic pressed,
    output logic released
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             state_q, state_d;
    logic             pressed_q, pressed_d;
    logic             released_q, released_d;
    logic             accept;

    always_comb begin
        cnt_d   = '0;
        state_d = state_q;
        accept  = 1'b0;
        if (sync2_q != state_q) begin
            if (cnt_q == CNT_MAX) begin
                accept  = 1'b1;
                state_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // A new event takes priority over a clear arriving in the same cycle.
        pressed_d  = (pressed_q  & ~clear) | (accept &  sync2_q);
        released_d = (released_q & ~clear) | (accept & ~sync2_q);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            cnt_q      <= '0;
            state_q    <= 1'b0;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
        end
    end

    assign state    = state_q;
    assign pressed  = pressed_q;
    assign released = released_q;

endmodule : debounce_channel
`default_nettype wire

// File: rtl/panel_inputs.sv
`default_nettype none
// ============================================================================
// Module   : panel_inputs
// Brief    : Front-panel button sampler: polarity fix, per-channel debounce.
// Revision : 1.0
// ============================================================================
module panel_inputs
    import panel_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF,
    parameter bit ACTIVE_LOW      = ACTIVE_LOW_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] buttons_raw,
    input  logic [WIDTH-1:0] clear_mask,
    output logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] pressed,
    output logic [WIDTH-1:0] released,
    // "event" is a reserved word, hence the suffix.
    output logic             event_o
);

    logic [WIDTH-1:0] w_raw;

    assign w_raw = buttons_raw ^ {WIDTH{ACTIVE_LOW}};

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_ch
            debounce_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_ch (
                .clock    (clock),
                .reset_n  (reset_n),
                .raw      (w_raw[i]),
                .clear    (clear_mask[i]),
                .state    (state[i]),
                .pressed  (pressed[i]),
                .released (released[i])
            );
        end
    endgenerate

    assign event_o = |(pressed | released);

endmodule : panel_inputs
`default_nettype wire

// File: tb/tb_panel_inputs.sv
`default_nettype none
// ============================================================================
// Module   : tb_panel_inputs
// Brief    : Directed self-checking bench for panel_inputs (DEBOUNCE_CYCLES=4).
// Revision : 1.0
// ============================================================================
module tb_panel_inputs;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset_n;
    logic [WIDTH-1:0] buttons_raw;
    logic [WIDTH-1:0] clear_mask;
    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] pressed;
    logic [WIDTH-1:0] released;
    logic             event_o;

    int n_checks = 0;
    int n_fail   = 0;

    panel_inputs #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clock       (clk),
        .reset_n     (reset_n),
        .buttons_raw (buttons_raw),
        .clear_mask  (clear_mask),
        .state       (state),
        .pressed     (pressed),
        .released    (released),
        .event_o     (event_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        buttons_raw = 8'hFF;
        clear_mask  = 8'h00;
        tick(3);
        check("rst_state",    32'(state),    32'h00);
        check("rst_pressed",  32'(pressed),  32'h00);
        check("rst_released", 32'(released), 32'h00);
        check("rst_event",    32'(event_o),  32'h0);

        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("idle_state", 32'(state), 32'h00);
        end

        // Clean press on bit 0: accepted on the 6th edge.
        buttons_raw[0] = 1'b0;
        tick(5);
        check("press_early", 32'(state), 32'h00);
        tick(1);
        check("press_state",    32'(state),    32'h01);
        check("press_pressed",  32'(pressed),  32'h01);
        check("press_released", 32'(released), 32'h00);
        check("press_event",    32'(event_o),  32'h1);

        clear_mask = 8'h01;
        tick(1);
        clear_mask = 8'h00;
        check("clr_pressed", 32'(pressed), 32'h00);
        check("clr_event",   32'(event_o), 32'h0);

        // Release completes on the same edge as a clear: set wins.
        buttons_raw[0] = 1'b1;
        tick(5);
        clear_mask = 8'h01;
        tick(1);
        clear_mask = 8'h00;
        check("setwin_state",    32'(state),    32'h00);
        check("setwin_released", 32'(released), 32'h01);
        check("setwin_pressed",  32'(pressed),  32'h00);
        clear_mask = 8'h01;
        tick(1);
        clear_mask = 8'h00;
        check("clr_released", 32'(released), 32'h00);

        // Glitch of 3 cycles on bit 3 is rejected.
        buttons_raw[3] = 1'b0;
        tick(3);
        buttons_raw[3] = 1'b1;
        tick(8);
        check("glitch_state",    32'(state),    32'h00);
        check("glitch_pressed",  32'(pressed),  32'h00);
        check("glitch_released", 32'(released), 32'h00);

        // 4 cycles low is just long enough; the return high then debounces back.
        buttons_raw[3] = 1'b0;
        tick(4);
        buttons_raw[3] = 1'b1;
        tick(1);
        check("g4_early", 32'(state), 32'h00);
        tick(1);
        check("g4_state",   32'(state),   32'h08);
        check("g4_pressed", 32'(pressed), 32'h08);
        tick(4);
        check("g4_back_state", 32'(state),    32'h00);
        check("g4_released",   32'(released), 32'h08);
        check("g4_both",       32'(pressed),  32'h08);
        clear_mask = 8'hFF;
        tick(1);
        clear_mask = 8'h00;
        check("clrall_pressed",  32'(pressed),  32'h00);
        check("clrall_released", 32'(released), 32'h00);
        check("clrall_event",    32'(event_o),  32'h0);

        // Bits 1 and 7 pressed one cycle apart.
        buttons_raw[1] = 1'b0;
        tick(1);
        buttons_raw[7] = 1'b0;
        tick(5);
        check("multi_first", 32'(state), 32'h02);
        tick(1);
        check("multi_state",   32'(state),   32'h82);
        check("multi_pressed", 32'(pressed), 32'h82);
        clear_mask = 8'h02;
        tick(1);
        clear_mask = 8'h00;
        check("multi_clr_pressed", 32'(pressed), 32'h80);
        check("multi_clr_event",   32'(event_o), 32'h1);

        // Reset in the middle of a count on bit 2.
        buttons_raw[2] = 1'b0;
        tick(4);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_state",    32'(state),    32'h00);
        check("mid_rst_pressed",  32'(pressed),  32'h00);
        check("mid_rst_released", 32'(released), 32'h00);
        check("mid_rst_event",    32'(event_o),  32'h0);
        tick(2);
        reset_n = 1'b1;
        tick(5);
        check("post_rst_early", 32'(state), 32'h00);
        tick(1);
        check("post_rst_state",   32'(state),   32'h86);
        check("post_rst_pressed", 32'(pressed), 32'h86);
        check("post_rst_event",   32'(event_o), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_panel_inputs
`default_nettype wire
